unstriping_pipe: RTL and testbench

UNSTRIPING_PIPE -- requirements
Module: unstriping_pipe

---
 rtl/unstriping_pipe_if.sv | 30 +++
 rtl/unstriping_pipe.sv | 112 +++++++++++
 tb/tb_unstriping_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unstriping_pipe_if.sv
// Stream bundle for unstriping_pipe: striped PIPE beats in, byte-ordered beats out.
// master = beat producer / consumer side, slave = the unstriping block.
interface unstriping_pipe_if #(
    parameter int MAX_LANES = 16,
    parameter int MAX_PW    = 32
);
    localparam int DW = MAX_LANES * MAX_PW;
    localparam int KW = DW / 8;

    logic [5:0]    PIPEWIDTH;
    logic [4:0]    LANESNUMBER;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] strippedData;
    logic [KW-1:0] strippedDataK;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] unstripedData;
    logic [KW-1:0] unstripedDataK;

    modport master (
        output PIPEWIDTH, LANESNUMBER, in_valid, strippedData, strippedDataK, out_ready,
        input  in_ready, out_valid, unstripedData, unstripedDataK
    );

    modport slave (
        input  PIPEWIDTH, LANESNUMBER, in_valid, strippedData, strippedDataK, out_ready,
        output in_ready, out_valid, unstripedData, unstripedDataK
    );
endinterface

// File: rtl/unstriping_pipe.sv
// Reorders per-lane PIPE bytes into one MSB-first byte stream (index = byte*lanes + lane)
// behind a single valid/ready output register stage, with a delivered-beat counter.
module unstriping_pipe #(
    parameter int MAX_LANES = 16,
    parameter int MAX_PW    = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    unstriping_pipe_if.slave bus,
    output logic             cfg_err,
    output logic [CNT_W-1:0] beat_cnt
);
    localparam int DW  = MAX_LANES * MAX_PW;
    localparam int KW  = DW / 8;
    localparam int BPL = MAX_PW / 8;
    localparam int AW  = (KW > 1) ? $clog2(KW) : 1;

    int               n_lanes;
    int               n_shift;
    int               w_bytes;
    logic             lanes_ok;
    logic             width_ok;
    logic             cfg_legal;
    logic [DW-1:0]    next_data;
    logic [KW-1:0]    next_k;
    logic [DW-1:0]    data_q;
    logic [KW-1:0]    k_q;
    logic             out_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             handshake;

    // Lane count is a power of two, so stream index splits into lane = low bits, byte = high bits.
    always_comb begin
        n_lanes  = 1;
        n_shift  = 0;
        lanes_ok = 1'b1;
        case (bus.LANESNUMBER)
            5'd1:    begin n_lanes = 1;  n_shift = 0; end
            5'd2:    begin n_lanes = 2;  n_shift = 1; end
            5'd4:    begin n_lanes = 4;  n_shift = 2; end
            5'd8:    begin n_lanes = 8;  n_shift = 3; end
            5'd16:   begin n_lanes = 16; n_shift = 4; end
            default: lanes_ok = 1'b0;
        endcase
        if (n_lanes > MAX_LANES) begin
            lanes_ok = 1'b0;
        end

        w_bytes  = 1;
        width_ok = 1'b1;
        case (bus.PIPEWIDTH)
            6'd8:    w_bytes = 1;
            6'd16:   w_bytes = 2;
            6'd32:   w_bytes = 4;
            default: width_ok = 1'b0;
        endcase
        if (w_bytes > BPL) begin
            width_ok = 1'b0;
        end
    end

    assign cfg_legal = lanes_ok && width_ok;

    for (genvar i = 0; i < KW; i++) begin : g_byte
        logic [AW-1:0] src;
        logic          active;

        always_comb begin
            src    = AW'((i & (n_lanes - 1)) * BPL + (i >> n_shift));
            active = cfg_legal && (i < n_lanes * w_bytes);
        end

        assign next_data[DW-1-8*i -: 8] = active ? bus.strippedData[{src, 3'b000} +: 8] : 8'h00;
        assign next_k[KW-1-i]           = active & bus.strippedDataK[src];
    end

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign handshake    = out_valid_q && bus.out_ready;

    // A new accept takes priority over draining, so a simultaneous handshake+accept keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            k_q         <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                data_q      <= next_data;
                k_q         <= next_k;
                err_q       <= !cfg_legal;
            end else if (handshake) begin
                out_valid_q <= 1'b0;
            end
            if (handshake) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.unstripedData  = data_q;
    assign bus.unstripedDataK = k_q;
    assign cfg_err            = err_q;
    assign beat_cnt           = cnt_q;
endmodule

// File: tb/tb_unstriping_pipe.sv
// Self-checking bench for unstriping_pipe: directed scenarios plus a randomized run
// against a byte-stream reference model.
module tb_unstriping_pipe;
    localparam int MAX_LANES = 16;
    localparam int MAX_PW    = 32;
    localparam int CNT_W     = 10;
    localparam int DW        = MAX_LANES * MAX_PW;
    localparam int KW        = DW / 8;
    localparam int BPL       = MAX_PW / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_err;
    logic [CNT_W-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [KW-1:0] exp_k;
    logic          exp_err;
    int            exp_cnt;

    int lanes_tbl [5] = '{1, 2, 4, 8, 16};
    int width_tbl [3] = '{8, 16, 32};

    unstriping_pipe_if #(.MAX_LANES(MAX_LANES), .MAX_PW(MAX_PW)) bus ();

    unstriping_pipe #(
        .MAX_LANES(MAX_LANES),
        .MAX_PW   (MAX_PW),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .cfg_err (cfg_err),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Reference: gather active lane bytes into a flat stream, then pack index 0 at the MSB end.
    function automatic void model_beat(input int pw, input int lanes,
                                       input logic [DW-1:0] din, input logic [KW-1:0] kin,
                                       output logic [DW-1:0] dout, output logic [KW-1:0] kout,
                                       output logic err);
        logic [7:0] s_byte [KW];
        logic       s_k    [KW];
        int         nbytes;
        dout = '0;
        kout = '0;
        err  = !((lanes inside {1, 2, 4, 8, 16}) && (pw inside {8, 16, 32}) &&
                 (lanes <= MAX_LANES) && (pw <= MAX_PW));
        if (err) return;
        for (int l = 0; l < lanes; l++) begin
            for (int b = 0; b < pw / 8; b++) begin
                s_byte[b * lanes + l] = din[l * MAX_PW + 8 * b +: 8];
                s_k[b * lanes + l]    = kin[l * BPL + b];
            end
        end
        nbytes = lanes * pw / 8;
        for (int i = 0; i < nbytes; i++) begin
            dout[DW - 1 - 8 * i -: 8] = s_byte[i];
            kout[KW - 1 - i]          = s_k[i];
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[32 * j +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive_beat(input int lanes, input int pw,
                              input logic [DW-1:0] d, input logic [KW-1:0] k);
        bus.LANESNUMBER   = 5'(lanes);
        bus.PIPEWIDTH     = 6'(pw);
        bus.strippedData  = d;
        bus.strippedDataK = k;
    endtask

    // One clock: advance the reference from the inputs seen before the edge, then settle past it.
    task automatic cycle();
        logic hs;
        logic acc;
        @(negedge clk);
        hs  = exp_valid && bus.out_ready;
        acc = bus.in_valid && (!exp_valid || bus.out_ready);
        if (acc) begin
            model_beat(int'(bus.PIPEWIDTH), int'(bus.LANESNUMBER), bus.strippedData,
                       bus.strippedDataK, exp_data, exp_k, exp_err);
            exp_valid = 1'b1;
        end else if (hs) begin
            exp_valid = 1'b0;
        end
        if (hs) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_k     = '0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #1 clear_model();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.unstripedData !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.unstripedData); end
        checks++; if (bus.unstripedDataK !== '0) begin errors++; $display("[TB] FAIL reset_k: got %h expected 0", bus.unstripedDataK); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_full_map();
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        for (int l = 0; l < 16; l++)
            for (int b = 0; b < 4; b++) d[l * 32 + 8 * b +: 8] = 8'(16 * b + l);
        for (int i = 0; i < KW; i++) want[DW - 1 - 8 * i -: 8] = 8'(i);
        drive_beat(16, 32, d, 64'h1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_map_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.unstripedData !== want) begin errors++; $display("[TB] FAIL full_map_data: got %h expected %h", bus.unstripedData, want); end
        checks++; if (bus.unstripedDataK !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL full_map_k: got %h expected 8000000000000000", bus.unstripedDataK); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL full_map_err: got %b expected 0", cfg_err); end
        cycle();
    endtask

    task automatic test_narrow();
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        d = '1;
        for (int l = 0; l < 4; l++) d[l * MAX_PW +: 8] = 8'(8'hA0 + l);
        want = '0;
        want[DW-1 -: 32] = 32'hA0A1_A2A3;
        drive_beat(4, 8, d, '1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.unstripedData !== want) begin errors++; $display("[TB] FAIL narrow_data: got %h expected %h", bus.unstripedData, want); end
        checks++; if (bus.unstripedDataK !== 64'hF000_0000_0000_0000) begin errors++; $display("[TB] FAIL narrow_k: got %h expected f000000000000000", bus.unstripedDataK); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL narrow_err: got %b expected 0", cfg_err); end
        cycle();
    endtask

    task automatic test_illegal();
        drive_beat(3, 16, rand_data(), {$urandom, $urandom});
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.unstripedData !== '0) begin errors++; $display("[TB] FAIL illegal_data: got %h expected 0", bus.unstripedData); end
        checks++; if (bus.unstripedDataK !== '0) begin errors++; $display("[TB] FAIL illegal_k: got %h expected 0", bus.unstripedDataK); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err: got %b expected 1", cfg_err); end
        drive_beat(2, 16, rand_data(), {$urandom, $urandom});
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_clear_err: got %b expected 0", cfg_err); end
        checks++; if (bus.unstripedData !== exp_data) begin errors++; $display("[TB] FAIL illegal_next_data: got %h expected %h", bus.unstripedData, exp_data); end
        drive_beat(16, 24, rand_data(), '1);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1 || bus.unstripedData !== '0) begin errors++; $display("[TB] FAIL illegal_width: got err=%b data=%h expected err=1 data=0", cfg_err, bus.unstripedData); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [3];
        logic [KW-1:0] k [3];
        logic [DW-1:0] wd [3];
        logic [KW-1:0] wk [3];
        logic          we;
        int            ln [3];
        int            pw [3];
        do_reset();
        for (int n = 0; n < 3; n++) begin
            d[n]  = rand_data();
            k[n]  = {$urandom, $urandom};
            ln[n] = lanes_tbl[$urandom_range(0, 4)];
            pw[n] = width_tbl[$urandom_range(0, 2)];
            model_beat(pw[n], ln[n], d[n], k[n], wd[n], wk[n], we);
        end
        drive_beat(ln[0], pw[0], d[0], k[0]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        drive_beat(ln[1], pw[1], d[1], k[1]);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_ready: got %b expected 0", bus.in_ready); end
            cycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.unstripedData !== wd[0] || bus.unstripedDataK !== wk[0]) begin errors++; $display("[TB] FAIL b2b_hold: got %h expected %h", bus.unstripedData, wd[0]); end
        end
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.unstripedData !== wd[1] || bus.unstripedDataK !== wk[1]) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", bus.unstripedData, wd[1]); end
        drive_beat(ln[2], pw[2], d[2], k[2]);
        cycle();
        checks++; if (bus.unstripedData !== wd[2] || bus.unstripedDataK !== wk[2]) begin errors++; $display("[TB] FAIL b2b_third: got %h expected %h", bus.unstripedData, wd[2]); end
        bus.in_valid = 1'b0;
        cycle();
        checks++; if (beat_cnt !== CNT_W'(3)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", beat_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_random();
        int ln;
        int pw;
        for (int n = 0; n < 300; n++) begin
            ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : lanes_tbl[$urandom_range(0, 4)];
            pw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : width_tbl[$urandom_range(0, 2)];
            drive_beat(ln, pw, rand_data(), {$urandom, $urandom});
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++; if (bus.in_ready !== (!exp_valid || bus.out_ready)) begin errors++; $display("[TB] FAIL rand_in_ready: got %b expected %b", bus.in_ready, !exp_valid || bus.out_ready); end
            cycle();
            checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rand_out_valid: got %b expected %b", bus.out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (bus.unstripedData !== exp_data) begin errors++; $display("[TB] FAIL rand_data: got %h expected %h", bus.unstripedData, exp_data); end
                checks++; if (bus.unstripedDataK !== exp_k) begin errors++; $display("[TB] FAIL rand_k: got %h expected %h", bus.unstripedDataK, exp_k); end
                checks++; if (cfg_err !== exp_err) begin errors++; $display("[TB] FAIL rand_cfg_err: got %b expected %b", cfg_err, exp_err); end
            end
            checks++; if (beat_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("[TB] FAIL rand_beat_cnt: got %0d expected %0d", beat_cnt, exp_cnt); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        drive_beat(8, 16, rand_data(), {$urandom, $urandom});
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_valid: got %b expected 1", bus.out_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_rst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.unstripedData !== '0 || bus.unstripedDataK !== '0) begin errors++; $display("[TB] FAIL stall_rst_data: got %h expected 0", bus.unstripedData); end
        checks++; if (beat_cnt !== '0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_rst_cnt: got cnt=%0d err=%b expected cnt=0 err=0", beat_cnt, cfg_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_rst_ready: got %b expected 1", bus.in_ready); end
        clear_model();
        @(posedge clk);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_stale: got %b expected 0", bus.out_valid); end
        drive_beat(1, 32, rand_data(), {$urandom, $urandom});
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.unstripedData !== exp_data) begin errors++; $display("[TB] FAIL stall_resume: got %h expected %h", bus.unstripedData, exp_data); end
        cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        drive_beat(4, 16, rand_data(), '0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < (1 << CNT_W); n++) cycle();
        checks++; if (beat_cnt !== CNT_W'((1 << CNT_W) - 1)) begin errors++; $display("[TB] FAIL wrap_preset: got %0d expected %0d", beat_cnt, (1 << CNT_W) - 1); end
        cycle();
        checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d expected 0", beat_cnt); end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        reset             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.PIPEWIDTH     = 6'd8;
        bus.LANESNUMBER   = 5'd1;
        bus.strippedData  = '0;
        bus.strippedDataK = '0;
        clear_model();
        #1 reset = 1'b1;
        #1;
        test_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        test_full_map();
        test_narrow();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
